// File: rtl/AluCtrlSig_pkg.sv
// Shared MIPS opcode/funct constants plus the stimulus-generator state type and LFSR helpers.
// Optional macro STIM_JUMP_EN widens the opcode mix to include J.
package AluCtrlSig_pkg;

  localparam logic [5:0] ADD_op  = 6'h00;
  localparam logic [5:0] J_op    = 6'h02;
  localparam logic [5:0] BEQ_op  = 6'h04;
  localparam logic [5:0] BNE_op  = 6'h05;
  localparam logic [5:0] ADDI_op = 6'h08;
  localparam logic [5:0] LW_op   = 6'h23;
  localparam logic [5:0] SW_op   = 6'h2B;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] XOR = 6'h26;
  localparam logic [5:0] NOR = 6'h27;
  localparam logic [5:0] SLT = 6'h2A;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

`ifdef STIM_JUMP_EN
  localparam int NOPS = 13;
`else
  localparam int NOPS = 12;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} stim_state_t;

  // Right-shifting Galois step: feedback bit is the LSB shifted out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ ({32{q[0]}} & LFSR_TAPS);
  endfunction

  function automatic logic [31:0] decode_inst(input logic [31:0] r);
    logic [3:0]  sel;
    logic [5:0]  funct;
    logic [31:0] w;
    sel   = 4'(r[3:0] % 4'(NOPS));
    funct = ADD;
    case (sel)
      4'd1:    funct = SUB;
      4'd2:    funct = AND;
      4'd3:    funct = OR;
      4'd4:    funct = NOR;
      4'd5:    funct = SLT;
      4'd6:    funct = XOR;
      default: ;
    endcase
    w = {ADD_op, r[8:4], r[13:9], r[18:14], 5'd0, funct};
    case (sel)
      4'd7:    w = {ADDI_op, r[8:4], r[13:9], r[31:16]};
      4'd8:    w = {LW_op, 5'd0, r[13:9], 11'd0, r[20:16]};
      4'd9:    w = {SW_op, 5'd0, r[13:9], 11'd0, r[20:16]};
      4'd10:   w = {BEQ_op, r[8:4], r[13:9], 12'd0, r[23:20]};
      4'd11:   w = {BNE_op, r[8:4], r[13:9], 12'd0, r[23:20]};
`ifdef STIM_JUMP_EN
      4'd12:   w = {J_op, 16'd0, r[31:22]};
`endif
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR: reset/load take the seed, adv steps once.
module lfsr32
  import AluCtrlSig_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || load) q <= seed;
    else if (adv)      q <= lfsr_next(q);
  end

endmodule

// File: rtl/mips_stim_gen.sv
// Issues NUM_INST pseudo-random MIPS instructions with a pcEn strobe and scores each by op_done.
// Define STIM_JUMP_EN to include J instructions in the generated mix.
module mips_stim_gen
  import AluCtrlSig_pkg::*;
#(
  parameter int          NUM_INST = 16,
  parameter int          RESP_WIN = 4,
  parameter logic [31:0] SEED     = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_done,
  output logic [31:0] inst,
  output logic        pcEn,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  stim_state_t state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] inst_cnt_q, inst_cnt_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] fail_q, fail_d;
  logic [3:0]  win_q, win_d;
  logic [31:0] lfsr_q;
  logic        adv;
  logic        load;

  // The LFSR sits at SEED throughout IDLE; only a reset ever reloads it otherwise.
  assign load = (state_q == IDLE) && !adv;

  lfsr32 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .adv   (adv),
    .seed  (SEED_EFF),
    .q     (lfsr_q)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_cnt_d = inst_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    win_d      = win_q;
    adv        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = ISSUE;
          inst_cnt_d = '0;
          pass_d     = '0;
          fail_d     = '0;
          adv        = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        win_d   = 4'd1;
      end
      WAIT: begin
        if (op_done) begin
          if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
          state_d = NEXT;
        end else if (win_q == 4'(RESP_WIN)) begin
          if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
          state_d = NEXT;
        end else begin
          win_d = win_q + 4'd1;
        end
      end
      NEXT: begin
        inst_cnt_d = inst_cnt_q + 16'd1;
        if (inst_cnt_d == 16'(NUM_INST)) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          adv     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Decode from the value the LFSR is about to take on this edge.
    if (adv) inst_d = decode_inst(lfsr_next(lfsr_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inst_q     <= '0;
      inst_cnt_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      inst_cnt_q <= inst_cnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      win_q      <= win_d;
    end
  end

  assign inst     = inst_q;
  assign pcEn     = (state_q == ISSUE);
  assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == NEXT);
  assign done     = (state_q == DONE);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_mips_stim_gen.sv
// Scoreboard bench for mips_stim_gen: instance A (4 instructions) for handshake/timing, B (1000) for opcode mix.
module tb_mips_stim_gen;

  localparam logic [31:0] SEED = 32'hACE1_1234;
`ifdef STIM_JUMP_EN
  localparam int NOPS_TB = 13;
`else
  localparam int NOPS_TB = 12;
`endif

  logic clk;
  logic reset_a, start_a, op_done_a;
  logic [31:0] inst_a;
  logic pcEn_a, busy_a, done_a;
  logic [15:0] pass_a, fail_a;
  logic reset_b, start_b, op_done_b;
  logic [31:0] inst_b;
  logic pcEn_b, busy_b, done_b;
  logic [15:0] pass_b, fail_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic [31:0] mdl_a, mdl_b;
  logic [31:0] run_first, first_after_reset;

  mips_stim_gen #(.NUM_INST(4), .RESP_WIN(4), .SEED(SEED)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .op_done(op_done_a),
    .inst(inst_a), .pcEn(pcEn_a), .busy(busy_a), .done(done_a),
    .pass_cnt(pass_a), .fail_cnt(fail_a));

  mips_stim_gen #(.NUM_INST(1000), .RESP_WIN(2), .SEED(SEED)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .op_done(op_done_b),
    .inst(inst_b), .pcEn(pcEn_b), .busy(busy_b), .done(done_b),
    .pass_cnt(pass_b), .fail_cnt(fail_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h80200003;
    return s;
  endfunction

  function automatic logic [31:0] mdl_decode(input logic [31:0] r);
    int sel;
    logic [5:0] fn[7];
    logic [4:0] rs, rt, rd;
    fn[0] = 6'h20; fn[1] = 6'h22; fn[2] = 6'h24; fn[3] = 6'h25;
    fn[4] = 6'h27; fn[5] = 6'h2A; fn[6] = 6'h26;
    sel = int'(r[3:0]) % NOPS_TB;
    rs = r[8:4]; rt = r[13:9]; rd = r[18:14];
    if (sel <= 6)       return {6'h00, rs, rt, rd, 5'd0, fn[sel]};
    else if (sel == 7)  return {6'h08, rs, rt, r[31:16]};
    else if (sel == 8)  return {6'h23, 5'd0, rt, 11'd0, r[20:16]};
    else if (sel == 9)  return {6'h2B, 5'd0, rt, 11'd0, r[20:16]};
    else if (sel == 10) return {6'h04, rs, rt, 12'd0, r[23:20]};
    else if (sel == 11) return {6'h05, rs, rt, 12'd0, r[23:20]};
    else                return {6'h02, 16'd0, r[31:22]};
  endfunction

  task automatic push_run_a();
    for (int i = 0; i < 4; i++) begin
      mdl_a = mdl_step(mdl_a);
      exp_q_a.push_back(mdl_decode(mdl_a));
    end
  endtask

  // mode 0: op_done two cycles after pcEn; 1: never; 2: only during ISSUE.
  task automatic run_a(input int mode, input int exp_len, input int exp_pass, input int exp_fail);
    int last_issue;
    int issues;
    bit got_done;
    logic [31:0] exp;
    last_issue = -1; issues = 0; got_done = 0;
    push_run_a();
    @(negedge clk);
    start_a = 1'b1;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      op_done_a = 1'b0;
      if (done_a) begin
        got_done = 1;
        n_cmp++;
        if (cyc - last_issue !== exp_len) begin
          n_bad++;
          $display("FAIL last_len mode%0d: got %0d want %0d", mode, cyc - last_issue, exp_len);
        end
      end else if (pcEn_a) begin
        exp = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 32'hDEAD_BEEF;
        if (issues == 0) run_first = inst_a;
        n_cmp++;
        if (inst_a !== exp) begin
          n_bad++;
          $display("FAIL inst mode%0d #%0d: got %h want %h", mode, issues, inst_a, exp);
        end
        if (last_issue >= 0) begin
          n_cmp++;
          if (cyc - last_issue !== exp_len) begin
            n_bad++;
            $display("FAIL inst_len mode%0d #%0d: got %0d want %0d", mode, issues, cyc - last_issue, exp_len);
          end
        end
        last_issue = cyc;
        issues++;
        if (mode == 2) op_done_a = 1'b1;
      end else if (mode == 0 && last_issue >= 0 && cyc - last_issue == 2) begin
        op_done_a = 1'b1;
      end
    end
    n_cmp++;
    if (!got_done) begin
      n_bad++;
      $display("FAIL timeout mode%0d: done never seen", mode);
    end
    n_cmp++;
    if (pass_a !== 16'(exp_pass) || fail_a !== 16'(exp_fail) || done_a !== 1'b1 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL end_state mode%0d: pass=%0d fail=%0d done=%b busy=%b want pass=%0d fail=%0d done=1 busy=0",
               mode, pass_a, fail_a, done_a, busy_a, exp_pass, exp_fail);
    end
    n_cmp++;
    if (issues !== 4) begin
      n_bad++;
      $display("FAIL issue_count mode%0d: got %0d want 4", mode, issues);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1; start_a = 1'b0; op_done_a = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; op_done_b = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({inst_a, pcEn_a, busy_a, done_a, pass_a, fail_a} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: inst=%h pcEn=%b busy=%b done=%b pass=%0d fail=%0d want all 0",
                 i, inst_a, pcEn_a, busy_a, done_a, pass_a, fail_a);
      end
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
    mdl_a = SEED;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pcEn_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_quiet cyc%0d: pcEn=%b busy=%b done=%b want 0", i, pcEn_a, busy_a, done_a);
      end
    end
  endtask

  task automatic test_pass();
    run_a(0, 4, 4, 0);
    first_after_reset = run_first;
  endtask

  task automatic test_fail();
    run_a(1, 6, 0, 4);
  endtask

  task automatic test_ignore_issue();
    run_a(2, 6, 0, 4);
  endtask

  task automatic test_mid_reset();
    int issues;
    bit fired;
    logic [31:0] exp;
    issues = 0; fired = 0;
    push_run_a();
    @(negedge clk);
    start_a = 1'b1;
    for (int cyc = 0; cyc < 100 && !fired; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (pcEn_a) begin
        exp = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (inst_a !== exp) begin
          n_bad++;
          $display("FAIL mid_inst #%0d: got %h want %h", issues, inst_a, exp);
        end
        issues++;
        if (issues == 3) begin
          @(negedge clk);
          reset_a = 1'b1;
          fired = 1;
        end
      end
    end
    n_cmp++;
    if (!fired) begin
      n_bad++;
      $display("FAIL mid_timeout: third issue never seen");
    end
    @(negedge clk);
    reset_a = 1'b0;
    n_cmp++;
    if ({inst_a, pcEn_a, busy_a, done_a, pass_a, fail_a} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: inst=%h pcEn=%b busy=%b done=%b pass=%0d fail=%0d want all 0",
               inst_a, pcEn_a, busy_a, done_a, pass_a, fail_a);
    end
    exp_q_a.delete();
    mdl_a = SEED;
    run_a(0, 4, 4, 0);
    n_cmp++;
    if (run_first !== first_after_reset) begin
      n_bad++;
      $display("FAIL restart_first: got %h want %h", run_first, first_after_reset);
    end
  endtask

  task automatic test_opcode_mix();
    int jcnt;
    int issues;
    bit got_done;
    bit seen_r, seen_addi, seen_lw, seen_sw, seen_beq, seen_bne;
    logic [31:0] exp;
    jcnt = 0; issues = 0; got_done = 0;
    seen_r = 0; seen_addi = 0; seen_lw = 0; seen_sw = 0; seen_beq = 0; seen_bne = 0;
    mdl_b = SEED;
    for (int i = 0; i < 1000; i++) begin
      mdl_b = mdl_step(mdl_b);
      exp_q_b.push_back(mdl_decode(mdl_b));
    end
    @(negedge clk);
    start_b = 1'b1;
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) got_done = 1;
      else if (pcEn_b) begin
        exp = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 32'hDEAD_BEEF;
        n_cmp++;
        if (inst_b !== exp) begin
          n_bad++;
          $display("FAIL mix_inst #%0d: got %h want %h", issues, inst_b, exp);
        end
        issues++;
        case (inst_b[31:26])
          6'h00: seen_r = 1;
          6'h02: jcnt++;
          6'h04: seen_beq = 1;
          6'h05: seen_bne = 1;
          6'h08: seen_addi = 1;
          6'h23: seen_lw = 1;
          6'h2B: seen_sw = 1;
          default: ;
        endcase
      end
    end
    n_cmp++;
    if (!got_done || issues !== 1000) begin
      n_bad++;
      $display("FAIL mix_run: done=%b issues=%0d want done=1 issues=1000", got_done, issues);
    end
    n_cmp++;
    if (fail_b !== 16'd1000 || pass_b !== 16'd0) begin
      n_bad++;
      $display("FAIL mix_counts: pass=%0d fail=%0d want pass=0 fail=1000", pass_b, fail_b);
    end
    n_cmp++;
`ifdef STIM_JUMP_EN
    if (jcnt == 0) begin
      n_bad++;
      $display("FAIL jump_count: got %0d want >0", jcnt);
    end
`else
    if (jcnt != 0) begin
      n_bad++;
      $display("FAIL jump_count: got %0d want 0", jcnt);
    end
`endif
    n_cmp++;
    if ({seen_r, seen_addi, seen_lw, seen_sw, seen_beq, seen_bne} !== 6'b111111) begin
      n_bad++;
      $display("FAIL opcode_cover: r/addi/lw/sw/beq/bne=%b want 111111",
               {seen_r, seen_addi, seen_lw, seen_sw, seen_beq, seen_bne});
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_ignore_issue();
    test_mid_reset();
    test_opcode_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
